// File: rtl/vga_tile_addr.sv
// Tile address generator: maps the active raster onto a COLS x ROWS grid of
// TILE_W x TILE_H tiles. Define VGA_TILE_PIX_EN to expose intra-tile offsets.
module vga_tile_addr #(
  parameter int TILE_W    = 160,
  parameter int TILE_H    = 120,
  parameter int COLS      = 4,
  parameter int ROWS      = 4,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 4,
  parameter bit VSYNC_ACT = 1'b0,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int HW = $clog2(TILE_W) + 1,
  localparam int VW = $clog2(TILE_H) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              video_on,
  input  logic              vsync,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [CW-1:0]     tile_col,
  output logic [RW-1:0]     tile_row,
  output logic              line_end,
`ifdef VGA_TILE_PIX_EN
  output logic              frame_start,
  output logic [HW-1:0]     px_off,
  output logic [VW-1:0]     py_off
`else
  output logic              frame_start
`endif
);

  localparam logic [0:0] WAIT_FRAME = 1'b0;
  localparam logic [0:0] ACTIVE     = 1'b1;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
  localparam logic [HW-1:0]     H_LAST   = HW'(TILE_W - 1);
  localparam logic [VW-1:0]     V_LAST   = VW'(TILE_H - 1);
  localparam bit ADDR_OK =
    (longint'(BASE_ADDR) + longint'(COLS) * longint'(ROWS) - 1) < (longint'(1) << ADDR_W);

  logic [0:0]        state;
  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic              video_on_r;
  logic              vsync_r;
  logic              vs_edge;
  logic              von_fall;
  logic [ADDR_W-1:0] addr_p0;

  // p0: edge detect and address of the current tile, from pre-update state
  assign vs_edge  = pix_en && (vsync == VSYNC_ACT) && (vsync_r != VSYNC_ACT);
  assign von_fall = pix_en && video_on_r && !video_on;
  assign addr_p0  = BASE_A + ADDR_W'(tile_row) * COLS_A + ADDR_W'(tile_col);

  // p1: registered outputs, one clock after the pix_en sample
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_FRAME;
      addr        <= BASE_A;
      addr_valid  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      tile_col    <= '0;
      tile_row    <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      video_on_r  <= 1'b0;
      vsync_r     <= ~VSYNC_ACT;
`ifdef VGA_TILE_PIX_EN
      px_off      <= '0;
      py_off      <= '0;
`endif
    end else begin
      assert (ADDR_OK);
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        video_on_r <= video_on;
        vsync_r    <= vsync;
        if (state == WAIT_FRAME) begin
          addr_valid <= 1'b0;
          if (vs_edge) begin
            state       <= ACTIVE;
            hcnt        <= '0;
            vcnt        <= '0;
            tile_col    <= '0;
            tile_row    <= '0;
            frame_start <= 1'b1;
          end
        end else if (vs_edge) begin
          hcnt        <= '0;
          vcnt        <= '0;
          tile_col    <= '0;
          tile_row    <= '0;
          frame_start <= 1'b1;
          addr_valid  <= 1'b0;
        end else if (von_fall) begin
          hcnt       <= '0;
          tile_col   <= '0;
          line_end   <= 1'b1;
          addr_valid <= 1'b0;
          if (vcnt == V_LAST) begin
            vcnt <= '0;
            if (tile_row != ROW_LAST) tile_row <= tile_row + RW'(1);
          end else begin
            vcnt <= vcnt + VW'(1);
          end
        end else if (video_on) begin
          addr       <= addr_p0;
          addr_valid <= 1'b1;
`ifdef VGA_TILE_PIX_EN
          px_off     <= hcnt;
          py_off     <= vcnt;
`endif
          // Columns beyond the grid keep reusing the last column's address
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (tile_col != COL_LAST) tile_col <= tile_col + CW'(1);
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end else begin
          addr_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_tile_addr.sv
// Bench for vga_tile_addr on a 4x2 grid of 4x2-pixel tiles based at address 8,
// with pix_en strobed every second clock.
module tb_vga_tile_addr;

  logic       clock = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       video_on;
  logic       vsync;
  logic [4:0] addr;
  logic       addr_valid;
  logic [1:0] tile_col;
  logic [0:0] tile_row;
  logic       line_end;
  logic       frame_start;
`ifdef VGA_TILE_PIX_EN
  logic [2:0] px_off;
  logic [1:0] py_off;
`endif

  vga_tile_addr #(
    .TILE_W(4), .TILE_H(2), .COLS(4), .ROWS(2),
    .BASE_ADDR(8), .ADDR_W(5), .VSYNC_ACT(1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pix_en(pix_en),
    .video_on(video_on),
    .vsync(vsync),
    .addr(addr),
    .addr_valid(addr_valid),
    .tile_col(tile_col),
    .tile_row(tile_row),
    .line_end(line_end),
`ifdef VGA_TILE_PIX_EN
    .px_off(px_off),
    .py_off(py_off),
`endif
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr; int valid; int col; int row; int le; int fs; int px; int py;
  } exp_t;

  typedef struct {
    bit   von;
    bit   vs;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  exp_t last;
  vec_t tbl[22];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(int a, int v, int c, int r, int le, int fs, int px, int py);
    exp_t e;
    e.addr = a; e.valid = v; e.col = c; e.row = r;
    e.le = le; e.fs = fs; e.px = px; e.py = py;
    return e;
  endfunction

  function automatic vec_t vec(bit von, bit vs, int a, int v, int c, int r,
                               int le, int fs, int px, int py);
    vec_t t;
    t.von = von; t.vs = vs; t.e = mk(a, v, c, r, le, fs, px, py);
    return t;
  endfunction

  function automatic int colf(int p);
    return (p / 4 > 3) ? 3 : p / 4;
  endfunction

  function automatic int rowf(int l);
    return (l / 2 > 1) ? 1 : l / 2;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, exp_t e);
    chk({tag, ".addr"}, int'(addr), e.addr);
    chk({tag, ".addr_valid"}, int'(addr_valid), e.valid);
    chk({tag, ".tile_col"}, int'(tile_col), e.col);
    chk({tag, ".tile_row"}, int'(tile_row), e.row);
    chk({tag, ".line_end"}, int'(line_end), e.le);
    chk({tag, ".frame_start"}, int'(frame_start), e.fs);
`ifdef VGA_TILE_PIX_EN
    chk({tag, ".px_off"}, int'(px_off), e.px);
    chk({tag, ".py_off"}, int'(py_off), e.py);
`endif
  endtask

  // One strobed pixel clock followed by one idle clock
  task automatic pix(input bit von, input bit vs, input exp_t e);
    @(negedge clock);
    pix_en = 1'b1; video_on = von; vsync = vs;
    sb.push_back(e);
    @(posedge clock); #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      last = sb.pop_front();
      chk_all("pix", last);
    end
    @(negedge clock);
    pix_en = 1'b0;
    @(posedge clock); #1;
    chk("idle.addr", int'(addr), last.addr);
    chk("idle.addr_valid", int'(addr_valid), last.valid);
    chk("idle.line_end", int'(line_end), 0);
    chk("idle.frame_start", int'(frame_start), 0);
  endtask

  task automatic run_line(input int l, input int n, input bit close);
    for (int p = 0; p < n; p++)
      pix(1'b1, 1'b1, mk(8 + rowf(l) * 4 + colf(p), 1, colf(p + 1), rowf(l), 0, 0, p % 4, l % 2));
    if (close)
      pix(1'b0, 1'b1, mk(last.addr, 0, 0, rowf(l + 1), 1, 0, last.px, last.py));
  endtask

  task automatic new_frame();
    pix(1'b0, 1'b0, mk(last.addr, 0, 0, 0, 0, 1, last.px, last.py));
  endtask

  initial begin
    // WAIT_FRAME pulses, vsync edge with video_on high, then a vsync edge that
    // lands on a video_on fall mid-frame.
    tbl[0]  = vec(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = vec(0, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = vec(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = vec(1, 0, 8, 0, 0, 0, 0, 1, 0, 0);
    tbl[4]  = vec(1, 0, 8, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = vec(1, 0, 8, 1, 0, 0, 0, 0, 1, 0);
    tbl[6]  = vec(1, 0, 8, 1, 0, 0, 0, 0, 2, 0);
    tbl[7]  = vec(1, 0, 8, 1, 1, 0, 0, 0, 3, 0);
    tbl[8]  = vec(1, 0, 9, 1, 1, 0, 0, 0, 0, 0);
    tbl[9]  = vec(1, 0, 9, 1, 1, 0, 0, 0, 1, 0);
    tbl[10] = vec(0, 1, 9, 0, 0, 0, 1, 0, 1, 0);
    tbl[11] = vec(1, 1, 8, 1, 0, 0, 0, 0, 0, 1);
    tbl[12] = vec(1, 1, 8, 1, 0, 0, 0, 0, 1, 1);
    tbl[13] = vec(1, 1, 8, 1, 0, 0, 0, 0, 2, 1);
    tbl[14] = vec(1, 1, 8, 1, 1, 0, 0, 0, 3, 1);
    tbl[15] = vec(1, 1, 9, 1, 1, 0, 0, 0, 0, 1);
    tbl[16] = vec(0, 0, 9, 0, 0, 0, 0, 1, 0, 1);
    tbl[17] = vec(1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
    tbl[18] = vec(1, 1, 8, 1, 0, 0, 0, 0, 1, 0);
    tbl[19] = vec(1, 1, 8, 1, 0, 0, 0, 0, 2, 0);
    tbl[20] = vec(1, 1, 8, 1, 1, 0, 0, 0, 3, 0);
    tbl[21] = vec(0, 1, 8, 0, 0, 0, 1, 0, 3, 0);

    reset = 1'b1; pix_en = 1'b0; video_on = 1'b0; vsync = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    last = mk(8, 0, 0, 0, 0, 0, 0, 0);
    chk_all("reset", last);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 22; i++)
      pix(tbl[i].von, tbl[i].vs, tbl[i].e);

    // Full frame: 16-pixel lines, then 20-pixel lines past the grid edge
    new_frame();
    for (int l = 0; l < 7; l++)
      run_line(l, (l < 2) ? 16 : 20, 1'b1);

    // Restart, stop mid-line 2 at address 13, then reset
    new_frame();
    run_line(0, 16, 1'b1);
    run_line(1, 16, 1'b1);
    run_line(2, 6, 1'b0);
    chk("pre_reset.addr", int'(addr), 13);
    @(negedge clock);
    reset = 1'b1; pix_en = 1'b1; video_on = 1'b1; vsync = 1'b1;
    @(posedge clock); #1;
    last = mk(8, 0, 0, 0, 0, 0, 0, 0);
    chk_all("mid_reset", last);
    @(negedge clock);
    reset = 1'b0; pix_en = 1'b0;

    // Back in WAIT_FRAME: pixels and line ends produce nothing
    pix(1'b1, 1'b1, mk(8, 0, 0, 0, 0, 0, 0, 0));
    pix(1'b1, 1'b1, mk(8, 0, 0, 0, 0, 0, 0, 0));
    pix(1'b0, 1'b1, mk(8, 0, 0, 0, 0, 0, 0, 0));
    pix(1'b1, 1'b1, mk(8, 0, 0, 0, 0, 0, 0, 0));

    chk("scoreboard.drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
